// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } mdu_state_e;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam int         MDU_ITERS = 32;

  // funct3[2] separates the divide/remainder group from the multiplies
  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: either two independent 32-bit conditional
// negations (operand magnitudes, quotient/remainder) or one 64-bit
// conditional negation of {hi, lo} (product).
module mdu_sign_fix (
  input  logic        wide_i,
  input  logic        neg_hi_i,
  input  logic        neg_lo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Conditional two's-complement negate, 64-bit or per-word
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (wide_i) begin
      if (neg_lo_i) {hi_o, lo_o} = 64'd0 - {hi_i, lo_i};
    end else begin
      if (neg_hi_i) hi_o = 32'd0 - hi_i;
      if (neg_lo_i) lo_o = 32'd0 - lo_i;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer sharing the core ALU for its
// per-bit add/subtract steps. Define MDU_DIV_EN to build the divide datapath;
// without it divide ops complete in cycle 3 with result 0 and illegal_o set.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        illegal_o,
  output logic        alu_req_o,
  output logic [31:0] alu_src_a_o,
  output logic [31:0] alu_src_b_o,
  output logic [3:0]  alu_control_o,
  input  logic [31:0] alu_result_i
);

  localparam logic [4:0] LAST_ITER = 5'(MDU_ITERS - 1);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [31:0] result_q, result_d, prev_q, prev_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, illegal_q, illegal_d;
`ifdef MDU_DIV_EN
  logic        rem_neg_q, rem_neg_d, bypass_q, bypass_d;
  logic [31:0] rem_shift;
  logic        take;
`endif

  logic        sign_a, sign_b, fix_wide, fix_neg_hi, sel_ill, carry;
  logic [31:0] mag_a, mag_b, fix_hi, fix_lo, sel_res, sum;

  // Raw operands sit in lo_q (rs1) and mcand_q (rs2) during SETUP
  assign sign_a = lo_q[31] & (op_q == OP_MULH || op_q == OP_MULHSU ||
                              op_q == OP_DIV  || op_q == OP_REM);
  assign sign_b = mcand_q[31] & (op_q == OP_MULH || op_q == OP_DIV ||
                                 op_q == OP_REM);

  mdu_sign_fix u_setup_fix (
    .wide_i   (1'b0),
    .neg_hi_i (sign_b),
    .neg_lo_i (sign_a),
    .hi_i     (mcand_q),
    .lo_i     (lo_q),
    .hi_o     (mag_b),
    .lo_o     (mag_a)
  );

`ifdef MDU_DIV_EN
  assign fix_wide   = !is_div(op_q);
  assign fix_neg_hi = rem_neg_q;
  assign rem_shift  = {hi_q[30:0], lo_q[31]};
  // Shifted-out remainder MSB means the 33-bit remainder already exceeds the divisor
  assign take       = hi_q[31] || (rem_shift >= mcand_q);
`else
  assign fix_wide   = 1'b1;
  assign fix_neg_hi = 1'b0;
`endif

  mdu_sign_fix u_result_fix (
    .wide_i   (fix_wide),
    .neg_hi_i (fix_neg_hi),
    .neg_lo_i (neg_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // Multiply step: add multiplicand when the current multiplier bit is set
  assign sum   = lo_q[0] ? alu_result_i : hi_q;
  assign carry = lo_q[0] && (alu_result_i < hi_q);

  // Final result word selection; corner-case results bypass re-signing
  always_comb begin
    sel_res = fix_lo;
    sel_ill = 1'b0;
    case (op_q)
      OP_MUL:                        sel_res = fix_lo;
      OP_MULH, OP_MULHSU, OP_MULHU:  sel_res = fix_hi;
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU:               sel_res = bypass_q ? lo_q : fix_lo;
      default:                       sel_res = bypass_q ? hi_q : fix_hi;
`else
      default: begin
        sel_res = '0;
        sel_ill = 1'b1;
      end
`endif
    endcase
  end

  // Next-state and datapath update for the sequencer FSM
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    result_d  = result_q;
    prev_d    = prev_q;
    illegal_d = 1'b0;
`ifdef MDU_DIV_EN
    rem_neg_d = rem_neg_q;
    bypass_d  = bypass_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = mdu_op_e'(op_i);
          lo_d    = rs1_i;
          mcand_d = rs2_i;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        hi_d    = '0;
        lo_d    = mag_a;
        mcand_d = mag_b;
        neg_d   = sign_a ^ sign_b;
        cnt_d   = '0;
        state_d = ST_ITER;
`ifdef MDU_DIV_EN
        rem_neg_d = sign_a;
        bypass_d  = 1'b0;
        if (is_div(op_q)) begin
          if (mcand_q == '0) begin
            lo_d     = 32'hFFFF_FFFF;
            hi_d     = lo_q;
            bypass_d = 1'b1;
            state_d  = ST_FIX;
          end else if (sign_b && lo_q == 32'h8000_0000 && mcand_q == 32'hFFFF_FFFF) begin
            lo_d     = 32'h8000_0000;
            hi_d     = '0;
            bypass_d = 1'b1;
            state_d  = ST_FIX;
          end
        end
`else
        // Pass through FIX so the illegal completion lands in cycle 3
        if (is_div(op_q)) state_d = ST_FIX;
`endif
      end
      ST_ITER: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
`ifdef MDU_DIV_EN
        if (is_div(op_q)) begin
          hi_d = take ? alu_result_i : rem_shift;
          lo_d = {lo_q[30:0], take};
        end else begin
`else
        begin
`endif
          hi_d = {carry, sum[31:1]};
          lo_d = {sum[0], lo_q[31:1]};
        end
      end
      ST_FIX: begin
        prev_d    = result_q;
        result_d  = sel_res;
        illegal_d = sel_ill;
        state_d   = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort: a flush during DONE rolls the result back to its previous value
    if (flush_i && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      illegal_d = 1'b0;
      result_d  = (state_q == ST_DONE) ? prev_q : result_q;
    end
  end

  // ALU request and operand drive, idle-zero outside ITER
  always_comb begin
    alu_req_o     = 1'b0;
    alu_src_a_o   = '0;
    alu_src_b_o   = '0;
    alu_control_o = ALU_ADD;
    if (state_q == ST_ITER) begin
      alu_req_o   = 1'b1;
      alu_src_a_o = hi_q;
      alu_src_b_o = mcand_q;
`ifdef MDU_DIV_EN
      if (is_div(op_q)) begin
        alu_src_a_o   = rem_shift;
        alu_control_o = ALU_SUB;
      end
`endif
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      prev_q    <= '0;
      illegal_q <= 1'b0;
`ifdef MDU_DIV_EN
      rem_neg_q <= 1'b0;
      bypass_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      prev_q    <= prev_d;
      illegal_q <= illegal_d;
`ifdef MDU_DIV_EN
      rem_neg_q <= rem_neg_d;
      bypass_q  <= bypass_d;
`endif
    end
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign done_o    = (state_q == ST_DONE) && !flush_i;
  assign illegal_o = illegal_q && !flush_i;
  assign result_o  = (state_q == ST_DONE && flush_i) ? prev_q : result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Table-driven bench for mdu_seq with a behavioural 32-bit ADD/SUB ALU.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o, done_o, illegal_o, alu_req_o;
  logic [31:0] result_o, alu_src_a_o, alu_src_b_o, alu_result;
  logic [3:0]  alu_control_o;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign alu_result = (alu_control_o == 4'h1) ? alu_src_a_o - alu_src_b_o
                                              : alu_src_a_o + alu_src_b_o;

  mdu_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .ready_o(ready_o),
    .done_o(done_o), .result_o(result_o), .illegal_o(illegal_o),
    .alu_req_o(alu_req_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_control_o(alu_control_o), .alu_result_i(alu_result)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic ill,
                              input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Divide expectations depend on whether the divide datapath is built
  function automatic void add_div(input string n, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] res, input int lat);
`ifdef MDU_DIV_EN
    add(n, op, a, b, res, 1'b0, lat);
`else
    add(n, op, a, b, 32'h0, 1'b1, 3);
`endif
  endfunction

  // Called on a negedge while idle; returns at the negedge after done (IDLE)
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ill, output int lat,
                        output int reqs, output logic alu_idle);
    res = '0; ill = 1'b0; lat = 0; reqs = 0; alu_idle = 1'b0;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (alu_req_o) reqs++;
      if (done_o) begin
        lat = c; res = result_o; ill = illegal_o;
        alu_idle = (alu_src_a_o == '0) && (alu_src_b_o == '0) && (alu_control_o == 4'h0) && !alu_req_o;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  logic [31:0] res, prev;
  logic        ill, alu_idle;
  int          lat, reqs, dones;

  initial begin
    add("mul_7_neg3",   3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 35);
    add("mulhu_m1_m1",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 35);
    add("mulh_m1_m1",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 35);
    add("mulhsu_m1_m1", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 35);
    add("mul_shift4",   3'b000, 32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 1'b0, 35);
    add("mulh_min_min", 3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 35);
    add_div("div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 35);
    add_div("rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 35);
    add_div("divu_100_7",   3'b101, 32'd100,       32'd7,          32'd14,        35);
    add_div("remu_100_7",   3'b111, 32'd100,       32'd7,          32'd2,         35);
    add_div("divu_5_0",     3'b101, 32'd5,         32'd0,          32'hFFFF_FFFF, 3);
    add_div("remu_5_0",     3'b111, 32'd5,         32'd0,          32'd5,         3);
    add_div("div_m7_0",     3'b100, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 3);
    add_div("rem_m7_0",     3'b110, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 3);
    add_div("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 3);
    add_div("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 3);
    add_div("div_8_2",      3'b100, 32'd8,         32'd2,          32'd4,         35);

    // Reset state
    #2;
    check("reset ready_o", {31'd0, ready_o}, 32'd1);
    check("reset done_o", {31'd0, done_o}, 32'd0);
    check("reset result_o", result_o, 32'd0);
    check("reset illegal_o", {31'd0, illegal_o}, 32'd0);
    check("reset alu outputs", {alu_src_a_o ^ alu_src_b_o, 31'd0, alu_req_o}
                               | {32'd0, 28'd0, alu_control_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, ill, lat, reqs, alu_idle);
      check({vecs[i].name, " result"}, res, vecs[i].res);
      check({vecs[i].name, " illegal"}, {31'd0, ill}, {31'd0, vecs[i].ill});
      check({vecs[i].name, " done cycle"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, " alu_req cycles"}, 32'(reqs), (vecs[i].lat == 35) ? 32'd32 : 32'd0);
      check({vecs[i].name, " alu idle at done"}, {31'd0, alu_idle}, 32'd1);
      check({vecs[i].name, " ready after"}, {31'd0, ready_o}, 32'd1);
    end

    // Flush in ITER cycle 10: no done, ready next cycle, result unchanged
    prev = result_o;
    start_i = 1'b1; op_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("flush alu_req in ITER", {31'd0, alu_req_o}, 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush ready next cycle", {31'd0, ready_o}, 32'd1);
    check("flush result unchanged", result_o, prev);
    dones = 0;
    repeat (40) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    check("flush no done", 32'(dones), 32'd0);

    // start_i pulse mid-operation is ignored
    start_i = 1'b1; op_i = 3'b000; rs1_i = 32'd6; rs2_i = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lat = 0; res = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin
        start_i = 1'b1; op_i = 3'b011; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'hFFFF_FFFF;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        lat = c; res = result_o;
        break;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check("ignored start result", res, 32'd42);
    check("ignored start done cycle", 32'(lat), 32'd35);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    check("ignored start no second done", 32'(dones), 32'd0);

    // Asynchronous reset mid-ITER
    start_i = 1'b1; op_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'hFFFF_FFFD;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset ready_o", {31'd0, ready_o}, 32'd1);
    check("async reset result_o", result_o, 32'd0);
    check("async reset done/illegal/req", {29'd0, done_o, illegal_o, alu_req_o}, 32'd0);
    check("async reset alu_src_a", alu_src_a_o, 32'd0);
    check("async reset alu_src_b", alu_src_b_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, ill, lat, reqs, alu_idle);
    check("after reset mul result", res, 32'hFFFF_FFEB);
    check("after reset mul done cycle", 32'(lat), 32'd35);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
